// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single RAM port, data-priority.
// Optional starvation guard for instruction fetch: MEM_ARBITER_STARVE_GUARD_EN.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate
);

    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

    state_t state;
    state_t state_n;
    logic   dreq;
    logic   done;
    logic   starved;

    assign dreq = dREN | dWEN;
    assign done = (ramstate == ACCESS);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    logic [3:0] starve;
    logic [3:0] starve_n;

    assign starved = (starve == 4'(STARVE_MAX));

    // Counter only moves at arbitration; it tracks data grants that
    // passed over a waiting instruction fetch.
    always_comb begin
        starve_n = starve;
        if (state == IDLE) begin
            if (state_n == DSERV && iREN)
                starve_n = starve + 4'd1;
            else
                starve_n = 4'd0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve <= 4'd0;
        else
            starve <= starve_n;
    end
`else
    assign starved = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        unique case (state)
            IDLE: begin
                if (iREN && starved)
                    state_n = ISERV;
                else if (dreq)
                    state_n = DSERV;
                else if (iREN)
                    state_n = ISERV;
            end
            DSERV: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq || done)
                    state_n = IDLE;
            end
            ISERV: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN || done)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;
    assign iwait = iREN & ~(state == ISERV && done);
    assign dwait = dreq & ~(state == DSERV && done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; RAM response driven cycle by cycle.
// Expected grant order depends on MEM_ARBITER_STARVE_GUARD_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .iwait   (iwait),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dload   (dload),
        .dwait   (dwait),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [5:0] exp_i;

    initial begin
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'd0;
        dstore   = 32'd0;
        ramload  = 32'h1234_5678;
        ramstate = FREE;

        // reset
        #12;
        check("rst ramREN", {31'd0, ramREN}, 32'd0);
        check("rst ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst iwait", {31'd0, iwait}, 32'd0);
        check("rst dload", dload, 32'h1234_5678);
        nRST = 1'b1;
        step();

        // instruction fetch, latency 2
        iREN = 1'b1;
        iaddr = 32'h40;
        #1;
        check("t1 bubble ramREN", {31'd0, ramREN}, 32'd0);
        check("t1 bubble iwait", {31'd0, iwait}, 32'd1);
        step();
        ramstate = BUSY;
        #1;
        check("t1 c1 ramREN", {31'd0, ramREN}, 32'd1);
        check("t1 c1 ramaddr", ramaddr, 32'h40);
        check("t1 c1 ramstore", ramstore, 32'd0);
        check("t1 c1 iwait", {31'd0, iwait}, 32'd1);
        step();
        #1;
        check("t1 c2 ramREN", {31'd0, ramREN}, 32'd1);
        step();
        ramstate = ACCESS;
        #1;
        check("t1 c3 ramREN", {31'd0, ramREN}, 32'd1);
        check("t1 c3 iwait", {31'd0, iwait}, 32'd0);
        check("t1 c3 iload", iload, 32'h1234_5678);
        iREN = 1'b0;
        step();
        ramstate = FREE;
        #1;
        check("t1 idle ramREN", {31'd0, ramREN}, 32'd0);

        // simultaneous requests, data wins
        iREN = 1'b1;
        iaddr = 32'h80;
        dWEN = 1'b1;
        daddr = 32'h100;
        dstore = 32'hDEAD_BEEF;
        #1;
        check("t2 bubble ramWEN", {31'd0, ramWEN}, 32'd0);
        check("t2 bubble dwait", {31'd0, dwait}, 32'd1);
        step();
        ramstate = BUSY;
        #1;
        check("t2 d ramWEN", {31'd0, ramWEN}, 32'd1);
        check("t2 d ramREN", {31'd0, ramREN}, 32'd0);
        check("t2 d ramaddr", ramaddr, 32'h100);
        check("t2 d ramstore", ramstore, 32'hDEAD_BEEF);
        check("t2 d iwait", {31'd0, iwait}, 32'd1);
        step();
        ramstate = ERROR;
        #1;
        check("t2 err hold", {31'd0, ramWEN}, 32'd1);
        step();
        ramstate = ACCESS;
        #1;
        check("t2 d dwait", {31'd0, dwait}, 32'd0);
        check("t2 d iwait", {31'd0, iwait}, 32'd1);
        dWEN = 1'b0;
        step();
        ramstate = FREE;
        #1;
        check("t2 bubble2 ramREN", {31'd0, ramREN}, 32'd0);
        check("t2 bubble2 iwait", {31'd0, iwait}, 32'd1);
        step();
        ramstate = ACCESS;
        #1;
        check("t2 i ramREN", {31'd0, ramREN}, 32'd1);
        check("t2 i ramaddr", ramaddr, 32'h80);
        check("t2 i iwait", {31'd0, iwait}, 32'd0);
        iREN = 1'b0;
        step();
        ramstate = FREE;

        // abort mid-grant
        dREN = 1'b1;
        daddr = 32'h200;
        step();
        ramstate = BUSY;
        #1;
        check("t4 ramREN", {31'd0, ramREN}, 32'd1);
        check("t4 ramaddr", ramaddr, 32'h200);
        dREN = 1'b0;
        #1;
        check("t4 drop dwait", {31'd0, dwait}, 32'd0);
        step();
        ramstate = ACCESS;
        #1;
        check("t4 idle ramREN", {31'd0, ramREN}, 32'd0);
        check("t4 idle ramWEN", {31'd0, ramWEN}, 32'd0);
        dREN = 1'b1;
        #1;
        check("t4 no completion", {31'd0, dwait}, 32'd1);
        step();
        #1;
        check("t4 regrant ramREN", {31'd0, ramREN}, 32'd1);
        check("t4 regrant dwait", {31'd0, dwait}, 32'd0);
        dREN = 1'b0;
        step();
        ramstate = FREE;

        // reset during ISERV
        iREN = 1'b1;
        iaddr = 32'h44;
        step();
        ramstate = BUSY;
        #1;
        check("t5 serve ramREN", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check("t5 async ramREN", {31'd0, ramREN}, 32'd0);
        step();
        nRST = 1'b1;
        ramstate = FREE;
        #1;
        check("t5 release ramREN", {31'd0, ramREN}, 32'd0);
        check("t5 release iwait", {31'd0, iwait}, 32'd1);
        step();
        ramstate = ACCESS;
        #1;
        check("t5 regrant ramREN", {31'd0, ramREN}, 32'd1);
        check("t5 regrant ramaddr", ramaddr, 32'h44);
        check("t5 regrant iwait", {31'd0, iwait}, 32'd0);
        iREN = 1'b0;
        step();
        ramstate = FREE;

        // sustained contention
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        exp_i = 6'b010000;
`else
        exp_i = 6'b000000;
`endif
        dREN = 1'b1;
        daddr = 32'h300;
        iREN = 1'b1;
        iaddr = 32'h48;
        for (int g = 0; g < 6; g++) begin
            ramstate = FREE;
            #1;
            check($sformatf("t3 bubble %0d", g), {31'd0, ramREN}, 32'd0);
            step();
            ramstate = ACCESS;
            #1;
            check($sformatf("t3 grant %0d", g), ramaddr,
                  exp_i[g] ? 32'h48 : 32'h300);
            check($sformatf("t3 iwait %0d", g), {31'd0, iwait},
                  exp_i[g] ? 32'd0 : 32'd1);
            step();
        end
        dREN = 1'b0;
        iREN = 1'b0;
        ramstate = FREE;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
